// File: rtl/game_controller.sv
// game_controller: brick-breaker game FSM with lives, score, brick map and paddle driving a field bitmap.
// Optional BRICKS_AUTOPILOT_EN makes the paddle track the ball column instead of the buttons.
module game_controller #(
  parameter int STEP_DIV    = 5000000,
  parameter int LIVES       = 3,
  parameter int SERVE_STEPS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic [3:0]   ball_row,
  input  logic [3:0]   ball_col,
  input  logic [1:0]   ball_dir,
  output logic [191:0] field,
  output logic         ball_step,
  output logic         ball_reset_n,
  output logic [2:0]   state,
  output logic [1:0]   lives,
  output logic [7:0]   score
);
  localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, OVER = 3'd3, WIN = 3'd4;
  localparam int CW = $clog2(STEP_DIV);
  localparam int SW = $clog2(SERVE_STEPS + 1);
  localparam logic [191:0] RELOAD = {128'd0, {48{1'b1}}, 16'd0};
  localparam logic [3:0] POS0 = 4'd7;
  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic [SW-1:0] serve_q, serve_d;
  logic [2:0]    state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [7:0]    score_q, score_d;
  logic [3:0]    pos_q, pos_d, pos_mv;
  logic [191:0]  bricks_q, bricks_d, field_q, field_d, clr, bricks_clr;
  logic          start_q, start_edge, step_tick, v_hit, h_hit, d_hit;
  logic [4:0]    vr, hc;
  logic [8:0]    score_sum;
  assign step_tick    = step_cnt_q == CW'(STEP_DIV - 1);
  assign step_cnt_d   = step_tick ? '0 : step_cnt_q + 1'b1;
  assign start_edge   = start & ~start_q;
  assign ball_step    = step_tick && state_q == PLAY;
  assign ball_reset_n = state_q == PLAY;
  // Neighbour arithmetic is done in 5 bits so a 4-bit wrap shows up as out of range.
  assign vr = {1'b0, ball_row} + (ball_dir[1] ? 5'd1 : 5'h1f);
  assign hc = {1'b0, ball_col} + (ball_dir[0] ? 5'd1 : 5'h1f);
  always_comb begin
    v_hit = vr < 5'd12 && bricks_q[{vr[3:0], ball_col}];
    h_hit = ball_row < 4'd12 && !hc[4] && bricks_q[{ball_row, hc[3:0]}];
    d_hit = !v_hit && !h_hit && vr < 5'd12 && !hc[4] && bricks_q[{vr[3:0], hc[3:0]}];
    clr = (v_hit ? 192'b1 << {vr[3:0], ball_col} : '0)
        | (h_hit ? 192'b1 << {ball_row, hc[3:0]} : '0)
        | (d_hit ? 192'b1 << {vr[3:0], hc[3:0]} : '0);
    bricks_clr = bricks_q & ~clr;
    score_sum = {1'b0, score_q} + {8'd0, v_hit} + {8'd0, h_hit} + {8'd0, d_hit};
  end
`ifdef BRICKS_AUTOPILOT_EN
  assign pos_mv = ball_col == 4'd0 ? 4'd0 : (ball_col - 4'd1 > 4'd13 ? 4'd13 : ball_col - 4'd1);
`else
  assign pos_mv = (btn_left && !btn_right) ? (pos_q == 4'd13 ? 4'd13 : pos_q + 4'd1)
                : (btn_right && !btn_left) ? (pos_q == 4'd0 ? 4'd0 : pos_q - 4'd1) : pos_q;
`endif
  always_comb begin
    state_d  = state_q;
    serve_d  = serve_q;
    lives_d  = lives_q;
    score_d  = score_q;
    bricks_d = bricks_q;
    pos_d    = step_tick && (state_q == SERVE || state_q == PLAY) ? pos_mv : pos_q;
    case (state_q)
      IDLE: if (start_edge) begin
        state_d = SERVE;
        serve_d = '0;
      end
      SERVE: if (step_tick) begin
        state_d = serve_q == SW'(SERVE_STEPS - 1) ? PLAY : SERVE;
        serve_d = serve_q + 1'b1;
      end
      PLAY: if (step_tick) begin
        bricks_d = bricks_clr;
        score_d  = score_sum[8] ? 8'hff : score_sum[7:0];
        if (ball_row == 4'd11) begin
          lives_d = lives_q - 2'd1;
          state_d = lives_q == 2'd1 ? OVER : SERVE;
          serve_d = '0;
        end else if (bricks_clr == '0) state_d = WIN;
      end
      OVER, WIN: if (start_edge) begin
        state_d  = IDLE;
        bricks_d = RELOAD;
        lives_d  = 2'(LIVES);
        score_d  = '0;
        pos_d    = POS0;
      end
      default: state_d = IDLE;
    endcase
    field_d = bricks_d | (192'h7 << (8'd176 + {4'd0, pos_d}));
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_cnt_q <= '0;
      serve_q    <= '0;
      state_q    <= IDLE;
      lives_q    <= 2'(LIVES);
      score_q    <= '0;
      pos_q      <= POS0;
      bricks_q   <= RELOAD;
      field_q    <= RELOAD | (192'h7 << (176 + 7));
      start_q    <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      serve_q    <= serve_d;
      state_q    <= state_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      pos_q      <= pos_d;
      bricks_q   <= bricks_d;
      field_q    <= field_d;
      start_q    <= start;
    end
  end
  assign field = field_q;
  assign state = state_q;
  assign lives = lives_q;
  assign score = score_q;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed checks of serve/play flow, brick clearing, lives, win, paddle clamp and reset.
module tb_game_controller;
  logic         clock = 1'b0, reset = 1'b0, start = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0]   ball_row = 4'd5, ball_col = 4'd0;
  logic [1:0]   ball_dir = 2'b10;
  logic [191:0] field;
  logic         ball_step, ball_reset_n;
  logic [2:0]   state;
  logic [1:0]   lives;
  logic [7:0]   score;
  int n_chk = 0, n_fail = 0;
  logic [191:0] exp_field0;
  game_controller #(.STEP_DIV(4), .LIVES(3), .SERVE_STEPS(4)) dut (
    .clock(clock), .reset(reset), .start(start), .btn_left(btn_left), .btn_right(btn_right),
    .ball_row(ball_row), .ball_col(ball_col), .ball_dir(ball_dir), .field(field),
    .ball_step(ball_step), .ball_reset_n(ball_reset_n), .state(state), .lives(lives), .score(score));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    @(negedge clock);
  endtask
  task automatic wait_play();
    int k = 0;
    while (state !== 3'd2 && k < 80) begin
      @(negedge clock);
      k++;
    end
    check("enter_play", {189'd0, state}, 192'd2);
  endtask
  task automatic play_tick(input logic [3:0] r, input logic [3:0] c, input logic [1:0] d);
    int k = 0;
    ball_row = r; ball_col = c; ball_dir = d;
    while (ball_step !== 1'b1 && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("tick_seen", {191'd0, ball_step}, 192'd1);
    @(negedge clock);
    ball_row = 4'd5; ball_col = 4'd0; ball_dir = 2'b10;
  endtask
  initial begin
    int k;
    exp_field0 = {128'd0, {48{1'b1}}, 16'd0} | (192'h7 << 183);
    repeat (3) @(negedge clock);
    check("rst_state", {189'd0, state}, 192'd0);
    check("rst_lives", {190'd0, lives}, 192'd3);
    check("rst_score", {184'd0, score}, 192'd0);
    check("rst_step", {191'd0, ball_step}, 192'd0);
    check("rst_brn", {191'd0, ball_reset_n}, 192'd0);
    check("rst_field", field, exp_field0);
    reset = 1'b1;
    pulse_start();
    check("serve_state", {189'd0, state}, 192'd1);
    check("serve_brn", {191'd0, ball_reset_n}, 192'd0);
    wait_play();
    check("play_brn", {191'd0, ball_reset_n}, 192'd1);
    k = 0;
    while (ball_step !== 1'b1 && k < 10) begin @(negedge clock); k++; end
    @(negedge clock);
    k = 1;
    while (ball_step !== 1'b1 && k < 10) begin @(negedge clock); k++; end
    check("step_period", 192'(k), 192'd4);
    @(negedge clock);
    play_tick(4'd4, 4'd9, 2'b00);
    check("v_clear57", {191'd0, field[57]}, 192'd0);
    check("keep56", {191'd0, field[56]}, 192'd1);
    check("score1", {184'd0, score}, 192'd1);
    play_tick(4'd4, 4'd0, 2'b00);
    check("v_clear48", {191'd0, field[48]}, 192'd0);
    check("score2", {184'd0, score}, 192'd2);
    play_tick(4'd2, 4'd0, 2'b00);
    check("v_clear16", {191'd0, field[16]}, 192'd0);
    check("no_wrap47", {191'd0, field[47]}, 192'd1);
    check("score3", {184'd0, score}, 192'd3);
    play_tick(4'd3, 4'd4, 2'b00);
    check("vh_clear", {190'd0, field[36], field[51]}, 192'd0);
    check("score5", {184'd0, score}, 192'd5);
    play_tick(4'd4, 4'd9, 2'b01);
    check("d_clear58", {191'd0, field[58]}, 192'd0);
    check("d_keep59", {191'd0, field[59]}, 192'd1);
    check("score6", {184'd0, score}, 192'd6);
    play_tick(4'd11, 4'd5, 2'b00);
    check("lost1", {187'd0, state, lives}, {187'd0, 3'd1, 2'd2});
    wait_play();
    play_tick(4'd11, 4'd5, 2'b00);
    check("lost2", {187'd0, state, lives}, {187'd0, 3'd1, 2'd1});
    wait_play();
    play_tick(4'd11, 4'd5, 2'b00);
    check("lost3", {187'd0, state, lives}, {187'd0, 3'd3, 2'd0});
    check("over_score", {184'd0, score}, 192'd6);
    pulse_start();
    check("idle_state", {189'd0, state}, 192'd0);
    check("idle_score", {184'd0, score}, 192'd0);
    check("idle_lives", {190'd0, lives}, 192'd3);
    check("idle_field", field, exp_field0);
    pulse_start();
    wait_play();
    btn_left = 1'b1;
    for (int i = 0; i < 20; i++) play_tick(4'd5, 4'd0, 2'b10);
    check("pad_max", {176'd0, field[191:176]}, 192'h0e000);
    btn_left = 1'b0; btn_right = 1'b1;
    for (int i = 0; i < 20; i++) play_tick(4'd5, 4'd0, 2'b10);
    check("pad_min", {176'd0, field[191:176]}, 192'h0007);
    btn_right = 1'b0; btn_left = 1'b1;
    play_tick(4'd5, 4'd0, 2'b10);
    check("pad_step", {176'd0, field[191:176]}, 192'h000e);
    btn_right = 1'b1;
    play_tick(4'd5, 4'd0, 2'b10);
    check("pad_both", {176'd0, field[191:176]}, 192'h000e);
    btn_left = 1'b0; btn_right = 1'b0;
    for (int r = 4; r >= 2; r--)
      for (int c = 0; c < 16; c++) begin
        if (r == 2 && c == 15) check("pre_win", {189'd0, state}, 192'd2);
        play_tick(4'(r), 4'(c), 2'b00);
      end
    check("win_state", {189'd0, state}, 192'd4);
    check("win_score", {184'd0, score}, 192'd48);
    check("win_empty", {144'd0, field[63:16]}, 192'd0);
    pulse_start();
    check("win_idle", {189'd0, state}, 192'd0);
    pulse_start();
    wait_play();
    play_tick(4'd4, 4'd9, 2'b00);
    check("pre_rst_score", {184'd0, score}, 192'd1);
    ball_row = 4'd4; ball_col = 4'd10; ball_dir = 2'b00;
    k = 0;
    while (ball_step !== 1'b1 && k < 10) begin @(negedge clock); k++; end
    check("pre_rst_tick", {191'd0, ball_step}, 192'd1);
    reset = 1'b0;
    #1;
    check("arst_state", {189'd0, state}, 192'd0);
    check("arst_lives", {190'd0, lives}, 192'd3);
    check("arst_score", {184'd0, score}, 192'd0);
    check("arst_step", {191'd0, ball_step}, 192'd0);
    check("arst_brn", {191'd0, ball_reset_n}, 192'd0);
    check("arst_field", field, exp_field0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter STEP_DIV, default 5000000: clock cycles per step tick (minimum 2).
REQ-002 SHALL have parameter LIVES, default 3: lives loaded at new game (1..3).
REQ-003 SHALL have parameter SERVE_STEPS, default 4: step ticks spent in SERVE.
REQ-004 SHALL have port clock  in  1: system clock.
REQ-005 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1: level button, rising edge used.
REQ-007 SHALL have ports btn_left, btn_right  in  1 each: paddle buttons, level.
REQ-008 SHALL have ports ball_row, ball_col  in  4 each: ball cell from ball engine.
REQ-009 SHALL have port ball_dir  in  2: 00 up-right, 01 up-left, 10 down-right, 11 down-left.
REQ-010 SHALL have port field  out  192: bit row*16+col set = occupied cell; drives the ball engine.
REQ-011 SHALL have ports ball_step, ball_reset_n  out  1 each: ball advance pulse and ball engine reset.
REQ-012 SHALL have ports state  out  3, lives  out  2, score  out  8.

Function
REQ-013 SHALL generate step_tick: one-cycle pulse every STEP_DIV cycles from a free-running counter.
REQ-014 SHALL use FSM states IDLE=0, SERVE=1, PLAY=2, OVER=3, WIN=4, output on state.
REQ-015 SHALL detect start rising edge with one register; edge acts in the next cycle.
REQ-016 IDLE + start edge -> SERVE with serve counter cleared.
REQ-017 SERVE -> PLAY on the SERVE_STEPS-th step tick.
REQ-018 ball_reset_n SHALL be 0 in IDLE, SERVE, OVER and WIN, and 1 only in PLAY.
REQ-019 ball_step SHALL equal step_tick gated by state==PLAY.
REQ-020 On a PLAY tick with ball_row==11: lives decrements; if the result is 0 -> OVER, else -> SERVE.
REQ-021 On a PLAY tick with the brick map all zero after clearing -> WIN; the ball-lost check of REQ-020 has priority.
REQ-022 OVER or WIN + start edge -> IDLE with brick map reloaded, lives=LIVES, score=0.
REQ-023 Brick map SHALL be 192 bits; reload value is rows 1..3, all 16 columns set (48 bricks).
REQ-024 Brick clearing SHALL be evaluated on each PLAY tick using pre-step ball_row/col/dir:
- dr = -1 if up, else +1; dc = -1 if right, else +1.
- V=(row+dr,col), H=(row,col+dc), D=(row+dr,col+dc).
- Clear V and H if they are in range and brick bits; if neither is cleared, clear D if it is a brick.
- Updated map appears on field the cycle after ball_step.
REQ-025 Out-of-range cells (row>11, col>15, 4-bit wrap) SHALL never be cleared.
REQ-026 score SHALL add the number of cleared bricks (0..2) per tick, saturating at 255.
REQ-027 Paddle SHALL be 3 cells in row 11 at cols pos..pos+2, pos 0..13, reset/reload pos=7.
REQ-028 On step ticks in SERVE/PLAY: btn_left only -> pos+1; btn_right only -> pos-1; both or neither -> hold; clamp at 0 and 13.
REQ-029 field SHALL be the brick map OR the paddle bits, registered.

Reset
REQ-030 On reset low: state=IDLE, lives=LIVES, score=0, pos=7, brick map=reload value, counters=0, ball_step=0, ball_reset_n=0.
REQ-031 Reset asserted mid-game SHALL abort immediately to these values with no partial clear.

Configuration
REQ-032 With BRICKS_AUTOPILOT_EN defined, SHALL set pos=clamp(ball_col-1, 0..13) on each SERVE/PLAY step tick and ignore buttons.
REQ-033 Without BRICKS_AUTOPILOT_EN, paddle SHALL follow REQ-028 only.

Verification (STEP_DIV=4, SERVE_STEPS=4, LIVES=3)
REQ-034 Reset then start edge -> state 1; after 4 ticks state 2; ball_reset_n rises and ball_step pulses every 4 cycles.
REQ-035 PLAY, ball (4,9) dir 00 (up-right), bricks rows 1..3 -> bit 3*16+9=57 cleared; score=1; field[57]=0 the cycle after ball_step.
REQ-036 PLAY, ball (4,0) dir 00 -> H=(4,15) out of range, not cleared; V=(3,0) cleared; score=1.
REQ-037 PLAY tick with ball_row=11 three times -> lives 2 (SERVE), 1 (SERVE), 0 (OVER); start edge -> IDLE with 48 bricks, score 0.
REQ-038 Map preloaded with only bit 57, ball (4,9) dir 00 -> WIN; hold btn_left 20 ticks -> pos stops at 13.
REQ-039 Assert reset during PLAY mid-tick -> all outputs equal REQ-030 values in the same cycle.
